// File: rtl/psum_pair_rx_if.sv
// psum_pair_rx_if
// Bundles the peer-link, local-sum and downstream-total handshakes of the
// partial-sum receiver, plus the peer FIFO occupancy.
//   slave  : the receiver (psum_pair_rx)
//   master : whatever drives the peer/local sums and consumes the total
// Parameters:
//   bw_psum : partial-sum base width; link sums are bw_psum+4 bits
//   depth   : peer FIFO depth (power of two, >= 2)
interface psum_pair_rx_if #(
  parameter int bw_psum = 19,
  parameter int depth   = 4
);
  localparam int SW = bw_psum + 4;
  localparam int TW = bw_psum + 5;
  localparam int CW = $clog2(depth) + 1;

  logic [SW-1:0] peer_sum;
  logic          peer_valid;
  logic          peer_ready;
  logic [SW-1:0] local_sum;
  logic          local_valid;
  logic          local_ready;
  logic [TW-1:0] total_out;
  logic          total_valid;
  logic          total_ready;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  peer_sum, peer_valid, local_sum, local_valid, total_ready,
    output peer_ready, local_ready, total_out, total_valid, fifo_count
  );

  modport master (
    output peer_sum, peer_valid, local_sum, local_valid, total_ready,
    input  peer_ready, local_ready, total_out, total_valid, fifo_count
  );
endinterface

// File: rtl/psum_pair_rx.sv
// psum_pair_rx
// Receive side of the inter-core partial-sum link. Peer sums are buffered
// in a small FIFO; each one is paired, in arrival order, with the local
// core's sum held in a one-entry register, and the registered total is
// handed to the normalization stage.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : psum_pair_rx_if.slave (peer/local/total handshakes, fifo_count)
// Build option:
//   PSUM_SAT_EN : when defined, total_out is clipped to bw_psum+4 bits
//                 (MSB always 0); otherwise the full bw_psum+5-bit sum.
module psum_pair_rx #(
  parameter int bw_psum = 19,
  parameter int depth   = 4
) (
  input  logic           clk,
  input  logic           reset,
  psum_pair_rx_if.slave  bus
);
  localparam int SW = bw_psum + 4;
  localparam int TW = bw_psum + 5;
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [SW-1:0] r_fifo [depth];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_local;
  logic          r_local_full;
  logic [TW-1:0] r_total_out;
  logic          r_total_valid;

  logic          w_peer_ready;
  logic          w_push;
  logic          w_load;
  logic          w_fire;
  logic [TW-1:0] w_sum_full;
  logic [TW-1:0] w_total;

  // No bypass: a full FIFO refuses a push even if it pops this cycle.
  assign w_peer_ready = (r_count < DEPTH_C);
  assign w_push       = bus.peer_valid && w_peer_ready;
  // Local register is only refilled once the previous entry has fired.
  assign w_load       = bus.local_valid && !r_local_full;
  assign w_fire       = r_local_full && (r_count != '0) &&
                        (!r_total_valid || bus.total_ready);

  assign w_sum_full = {1'b0, r_fifo[r_rptr]} + {1'b0, r_local};

`ifdef PSUM_SAT_EN
  assign w_total = w_sum_full[TW-1] ? {1'b0, {SW{1'b1}}} : w_sum_full;
`else
  assign w_total = w_sum_full;
`endif

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= bus.peer_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_local       <= '0;
      r_local_full  <= 1'b0;
      r_total_out   <= '0;
      r_total_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_fire) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_fire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_fire) begin
        r_count <= r_count - 1'b1;
      end

      if (w_fire) begin
        r_local_full <= 1'b0;
      end else if (w_load) begin
        r_local      <= bus.local_sum;
        r_local_full <= 1'b1;
      end

      if (w_fire) begin
        r_total_out   <= w_total;
        r_total_valid <= 1'b1;
      end else if (bus.total_ready) begin
        r_total_valid <= 1'b0;
      end
    end
  end

  assign bus.peer_ready  = w_peer_ready;
  assign bus.local_ready = !r_local_full;
  assign bus.total_out   = r_total_out;
  assign bus.total_valid = r_total_valid;
  assign bus.fifo_count  = r_count;
endmodule

// File: tb/tb_psum_pair_rx.sv
module tb_psum_pair_rx;
  localparam int BW = 19;
  localparam int DEPTH = 4;
  localparam int SW = BW + 4;
  localparam int TW = BW + 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [TW-1:0] exp_q [$];

  psum_pair_rx_if #(.bw_psum(BW), .depth(DEPTH)) bus ();

  psum_pair_rx #(.bw_psum(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every accepted total is compared against the oldest expected.
  always @(negedge clk) begin
    if (!reset && bus.total_valid && bus.total_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL total_unexpected got %0d expected none", bus.total_out);
      end else begin
        logic [TW-1:0] e;
        e = exp_q.pop_front();
        if (bus.total_out !== e) begin
          errors++;
          $display("FAIL total_value got %0d expected %0d", bus.total_out, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.peer_sum = '0; bus.peer_valid = 1'b0;
    bus.local_sum = '0; bus.local_valid = 1'b0;
    bus.total_ready = 1'b1;
    cyc(); cyc();
    checks++; if (bus.peer_ready !== 1'b1) begin errors++; $display("FAIL reset_peer_ready got %0b expected 1", bus.peer_ready); end
    checks++; if (bus.local_ready !== 1'b1) begin errors++; $display("FAIL reset_local_ready got %0b expected 1", bus.local_ready); end
    checks++; if (bus.total_valid !== 1'b0) begin errors++; $display("FAIL reset_total_valid got %0b expected 0", bus.total_valid); end
    checks++; if (bus.total_out !== '0) begin errors++; $display("FAIL reset_total_out got %0d expected 0", bus.total_out); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d expected 0", bus.fifo_count); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bus.total_ready = 1'b1;
    bus.peer_sum = SW'(100); bus.peer_valid = 1'b1;
    bus.local_sum = SW'(23); bus.local_valid = 1'b1;
    exp_q.push_back(TW'(123));
    cyc();
    bus.peer_valid = 1'b0; bus.local_valid = 1'b0;
    checks++; if (bus.total_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b expected 0", bus.total_valid); end
    cyc();
    checks++; if (bus.total_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid got %0b expected 1", bus.total_valid); end
    checks++; if (bus.total_out !== TW'(123)) begin errors++; $display("FAIL basic_total got %0d expected 123", bus.total_out); end
    cyc();
    checks++; if (bus.total_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got %0b expected 0", bus.total_valid); end
    drain("basic");
  endtask

  task automatic test_fifo_full();
    bus.total_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.peer_sum = SW'(i); bus.peer_valid = 1'b1;
      cyc();
    end
    bus.peer_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d expected 4", bus.fifo_count); end
    checks++; if (bus.peer_ready !== 1'b0) begin errors++; $display("FAIL full_peer_ready got %0b expected 0", bus.peer_ready); end
    bus.peer_sum = SW'(5); bus.peer_valid = 1'b1;
    cyc();
    bus.peer_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_drop_count got %0d expected 4", bus.fifo_count); end
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(TW'(10 + i));
      bus.local_sum = SW'(10); bus.local_valid = 1'b1;
      cyc();
      bus.local_valid = 1'b0;
      cyc();
    end
    drain("full");
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL full_empty_count got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_backpressure();
    bus.total_ready = 1'b0;
    bus.peer_sum = SW'(7); bus.peer_valid = 1'b1;
    bus.local_sum = SW'(0); bus.local_valid = 1'b1;
    exp_q.push_back(TW'(7));
    cyc();
    bus.peer_valid = 1'b0; bus.local_valid = 1'b0;
    cyc();
    bus.peer_sum = SW'(20); bus.peer_valid = 1'b1;
    bus.local_sum = SW'(5); bus.local_valid = 1'b1;
    exp_q.push_back(TW'(25));
    cyc();
    bus.peer_valid = 1'b0; bus.local_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (bus.total_out !== TW'(7) || bus.total_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got %0d/%0b expected 7/1", bus.total_out, bus.total_valid); end
      checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL bp_no_pop got %0d expected 1", bus.fifo_count); end
    end
    checks++; if (bus.local_ready !== 1'b0) begin errors++; $display("FAIL bp_local_ready got %0b expected 0", bus.local_ready); end
    bus.total_ready = 1'b1;
    cyc();
    checks++; if (bus.total_out !== TW'(25) || bus.total_valid !== 1'b1) begin errors++; $display("FAIL bp_release got %0d/%0b expected 25/1", bus.total_out, bus.total_valid); end
    drain("bp");
  endtask

  task automatic test_saturation();
    logic [TW-1:0] e1, e2;
`ifdef PSUM_SAT_EN
    e1 = TW'(24'h7F_FFFF);
    e2 = TW'(24'h7F_FFFF);
`else
    e1 = TW'(24'h80_0000);
    e2 = TW'(24'hFF_FFFE);
`endif
    bus.total_ready = 1'b1;
    bus.peer_sum = SW'(23'h7F_FFFF); bus.peer_valid = 1'b1;
    bus.local_sum = SW'(1); bus.local_valid = 1'b1;
    exp_q.push_back(e1);
    cyc();
    bus.peer_valid = 1'b0; bus.local_valid = 1'b0;
    cyc();
    checks++; if (bus.total_out !== e1) begin errors++; $display("FAIL sat_edge got %0d expected %0d", bus.total_out, e1); end
    bus.peer_sum = SW'(23'h7F_FFFF); bus.peer_valid = 1'b1;
    bus.local_sum = SW'(23'h7F_FFFF); bus.local_valid = 1'b1;
    exp_q.push_back(e2);
    cyc();
    bus.peer_valid = 1'b0; bus.local_valid = 1'b0;
    drain("sat");
  endtask

  task automatic test_reset_mid();
    bus.total_ready = 1'b0;
    bus.peer_sum = SW'(1); bus.peer_valid = 1'b1;
    bus.local_sum = SW'(1); bus.local_valid = 1'b1;
    cyc();
    bus.peer_valid = 1'b0; bus.local_valid = 1'b0;
    cyc();
    bus.local_sum = SW'(9); bus.local_valid = 1'b1;
    cyc();
    bus.local_valid = 1'b0;
    cyc();
    checks++; if (bus.local_ready !== 1'b0) begin errors++; $display("FAIL rmid_local_wait got %0b expected 0", bus.local_ready); end
    for (int i = 5; i <= 7; i++) begin
      bus.peer_sum = SW'(i); bus.peer_valid = 1'b1;
      cyc();
    end
    bus.peer_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL rmid_pre_count got %0d expected 3", bus.fifo_count); end
    reset = 1'b1;
    cyc();
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.peer_ready !== 1'b1) begin errors++; $display("FAIL rmid_peer_ready got %0b expected 1", bus.peer_ready); end
    checks++; if (bus.local_ready !== 1'b1) begin errors++; $display("FAIL rmid_local_ready got %0b expected 1", bus.local_ready); end
    checks++; if (bus.total_valid !== 1'b0) begin errors++; $display("FAIL rmid_total_valid got %0b expected 0", bus.total_valid); end
    reset = 1'b0;
    bus.total_ready = 1'b1;
    bus.peer_sum = SW'(40); bus.peer_valid = 1'b1;
    bus.local_sum = SW'(2); bus.local_valid = 1'b1;
    exp_q.push_back(TW'(42));
    cyc();
    bus.peer_valid = 1'b0; bus.local_valid = 1'b0;
    drain("rmid");
  endtask

  task automatic test_push_pop();
    bus.total_ready = 1'b1;
    bus.peer_sum = SW'(100); bus.peer_valid = 1'b1;
    cyc();
    bus.peer_sum = SW'(200);
    cyc();
    bus.peer_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd2) begin errors++; $display("FAIL pp_pre_count got %0d expected 2", bus.fifo_count); end
    exp_q.push_back(TW'(101));
    bus.local_sum = SW'(1); bus.local_valid = 1'b1;
    cyc();
    bus.local_valid = 1'b0;
    bus.peer_sum = SW'(300); bus.peer_valid = 1'b1;
    cyc();
    bus.peer_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd2) begin errors++; $display("FAIL pp_same_cycle_count got %0d expected 2", bus.fifo_count); end
    for (int i = 4; i <= 5; i++) begin
      bus.peer_sum = SW'(100 * i); bus.peer_valid = 1'b1;
      cyc();
    end
    bus.peer_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL pp_wrap_count got %0d expected 4", bus.fifo_count); end
    for (int v = 2; v <= 5; v++) begin
      exp_q.push_back(TW'(101 * v));
      bus.local_sum = SW'(v); bus.local_valid = 1'b1;
      cyc();
      bus.local_valid = 1'b0;
      cyc();
    end
    drain("pp");
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL pp_end_count got %0d expected 0", bus.fifo_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_fifo_full();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_push_pop();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
